text_console: RTL and testbench

Parametrised 8x16 text-mode renderer for the 640x480 HDMI path. It holds a COLS x ROWS character buffer, accepts a byte stream of ASCII characters and control codes on a valid/ready port, and maintains a cursor with line wrap and hardware scroll. It turns the (x, y) pixel coordinates from hdmi_video into a 24-bit color through the existing font_rom, with a fixed latency. It replaces single-glyph top-level rendering logic.

---
 rtl/text_console.sv | 232 +++++++++++++++++++++++
 tb/tb_text_console.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/text_console.sv
// Text-mode renderer: COLS x ROWS character buffer with cursor, wrap and hardware scroll,
// rendered through an 8x16 glyph ROM with a fixed 3-cycle pixel latency.

// Stand-in glyph ROM: 'M' is drawn as a real glyph; other printable codes show their own
// code as the bit pattern on glyph rows 2..13; space and non-printables are blank.
module font_rom (
    input  logic        clk,
    input  logic [11:0] addr,
    output logic [7:0]  data_out
);
    logic [7:0] ch;
    logic [3:0] row;
    logic [7:0] glyph;

    assign ch  = addr[11:4];
    assign row = addr[3:0];

    always_comb begin
        glyph = 8'h00;
        if (ch == 8'h4d) begin
            case (row)
                4'd2:                                   glyph = 8'hc3;
                4'd3:                                   glyph = 8'he7;
                4'd4:                                   glyph = 8'hff;
                4'd5:                                   glyph = 8'hdb;
                4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11:   glyph = 8'hc3;
                default:                                glyph = 8'h00;
            endcase
        end else if (ch > 8'h20 && ch < 8'h7f && row >= 4'd2 && row <= 4'd13) begin
            glyph = ch;
        end
    end

    always_ff @(posedge clk) begin
        data_out <= glyph;
    end
endmodule

// state      | meaning
// CLEAR_ALL  | blank every cell, home cursor, top=0
// IDLE       | accept bytes (wr_ready=1)
// CLEAR_LINE | blank the new bottom row after a scroll
module text_console #(
    parameter int          COLS         = 80,
    parameter int          ROWS         = 30,
    parameter logic [23:0] FG           = 24'hffffff,
    parameter logic [23:0] BG           = 24'h000000,
    parameter bit          CURSOR_EN    = 1'b1,
    parameter int          BLINK_FRAMES = 32
) (
    input  logic                     clk_25mhz,
    input  logic                     reset,
    input  logic [9:0]               x,
    input  logic [9:0]               y,
    output logic [23:0]              color,
    input  logic                     wr_valid,
    input  logic [7:0]               wr_data,
    output logic                     wr_ready,
    output logic [$clog2(COLS)-1:0]  cursor_col,
    output logic [$clog2(ROWS)-1:0]  cursor_row
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int AW = $clog2(COLS * ROWS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_LINE} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] clr_addr, clr_addr_nx;
    logic [AW-1:0] clr_cnt, clr_cnt_nx;
    logic [CW-1:0] cur_col, cur_col_nx;
    logic [RW-1:0] cur_row, cur_row_nx;
    logic [RW-1:0] top, top_nx;
    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic          newline;

    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] base,
                                                input logic [RW-1:0] lrow,
                                                input logic [CW-1:0] col);
        int phys;
        phys = int'(base) + int'(lrow);
        if (phys >= ROWS) phys = phys - ROWS;
        return AW'(phys * COLS + int'(col));
    endfunction

    assign wr_ready   = (state == IDLE);
    assign cursor_col = cur_col;
    assign cursor_row = cur_row;

    always_comb begin
        state_nx    = state;
        clr_addr_nx = clr_addr;
        clr_cnt_nx  = clr_cnt;
        cur_col_nx  = cur_col;
        cur_row_nx  = cur_row;
        top_nx      = top;
        we          = 1'b0;
        waddr       = clr_addr;
        wdata       = 8'h20;
        newline     = 1'b0;
        case (state)
            CLEAR_ALL, CLEAR_LINE: begin
                we          = 1'b1;
                clr_addr_nx = clr_addr + 1'b1;
                clr_cnt_nx  = clr_cnt - 1'b1;
                if (clr_cnt == '0) state_nx = IDLE;
            end
            IDLE: begin
                if (wr_valid) begin
                    if (wr_data >= 8'h20 && wr_data <= 8'h7e) begin
                        we    = 1'b1;
                        waddr = cell_addr(top, cur_row, cur_col);
                        wdata = wr_data;
                        if (int'(cur_col) == COLS - 1) newline = 1'b1;
                        else cur_col_nx = cur_col + 1'b1;
                    end else begin
                        case (wr_data)
                            8'h0d: cur_col_nx = '0;
                            8'h0a: newline = 1'b1;
                            8'h08: if (cur_col != '0) cur_col_nx = cur_col - 1'b1;
                            8'h0c: begin
                                state_nx    = CLEAR_ALL;
                                clr_addr_nx = '0;
                                clr_cnt_nx  = AW'(COLS * ROWS - 1);
                                top_nx      = '0;
                                cur_col_nx  = '0;
                                cur_row_nx  = '0;
                            end
                            default: ;
                        endcase
                    end
                    if (newline) begin
                        cur_col_nx = '0;
                        if (int'(cur_row) == ROWS - 1) begin
                            // the old top physical row becomes the new bottom row
                            top_nx      = (int'(top) == ROWS - 1) ? '0 : top + 1'b1;
                            clr_addr_nx = cell_addr(top, '0, '0);
                            clr_cnt_nx  = AW'(COLS - 1);
                            state_nx    = CLEAR_LINE;
                        end else begin
                            cur_row_nx = cur_row + 1'b1;
                        end
                    end
                end
            end
            default: state_nx = CLEAR_ALL;
        endcase
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            state    <= CLEAR_ALL;
            clr_addr <= '0;
            clr_cnt  <= AW'(COLS * ROWS - 1);
            cur_col  <= '0;
            cur_row  <= '0;
            top      <= '0;
        end else begin
            state    <= state_nx;
            clr_addr <= clr_addr_nx;
            clr_cnt  <= clr_cnt_nx;
            cur_col  <= cur_col_nx;
            cur_row  <= cur_row_nx;
            top      <= top_nx;
        end
    end

    logic [7:0]    mem [COLS * ROWS];
    logic [7:0]    rd_char;
    logic [AW-1:0] raddr;
    logic          in_area0, curs0;

    assign in_area0 = (int'(x) < COLS * 8) && (int'(y) < ROWS * 16);
    assign curs0    = in_area0 && (int'(x[9:3]) == int'(cur_col)) && (int'(y[8:4]) == int'(cur_row));
    assign raddr    = in_area0 ? cell_addr(top, RW'(y[8:4]), CW'(x[9:3])) : '0;

    always_ff @(posedge clk_25mhz) begin
        if (we) mem[waddr] <= wdata;
        rd_char <= mem[raddr];
    end

    logic [3:0]    yl_d1;
    logic [2:0]    xl_d1, xl_d2;
    logic          area_d1, area_d2, curs_d1, curs_d2;
    logic [7:0]    font_data;
    logic          pix_bit;
    logic          blink_on;
    logic [FW-1:0] frame_cnt;

    font_rom u_font (
        .clk      (clk_25mhz),
        .addr     ({rd_char, yl_d1}),
        .data_out (font_data)
    );

    assign pix_bit = font_data[3'd7 - xl_d2] ^ (curs_d2 && CURSOR_EN && blink_on);

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            yl_d1     <= '0;
            xl_d1     <= '0;
            xl_d2     <= '0;
            area_d1   <= 1'b0;
            area_d2   <= 1'b0;
            curs_d1   <= 1'b0;
            curs_d2   <= 1'b0;
            color     <= BG;
            blink_on  <= 1'b1;
            frame_cnt <= '0;
        end else begin
            yl_d1   <= y[3:0];
            xl_d1   <= x[2:0];
            xl_d2   <= xl_d1;
            area_d1 <= in_area0;
            area_d2 <= area_d1;
            curs_d1 <= curs0;
            curs_d2 <= curs_d1;
            color   <= (area_d2 && pix_bit) ? FG : BG;
            if (x == 10'd0 && y == 10'd0) begin
                if (int'(frame_cnt) == BLINK_FRAMES - 1) begin
                    frame_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: clear timing, glyph rendering, wrap, scroll,
// control codes, out-of-area and cursor blink, all against hand-computed values.
module tb_text_console;
    localparam logic [23:0] FG = 24'hffffff;
    localparam logic [23:0] BG = 24'h000000;

    logic        clk_25mhz = 1'b0;
    logic        reset;
    logic [9:0]  x, y;
    logic [23:0] color;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;

    int n_chk = 0;
    int n_bad = 0;

    text_console #(
        .COLS(80), .ROWS(30), .FG(FG), .BG(BG), .CURSOR_EN(1'b1), .BLINK_FRAMES(1)
    ) dut (
        .clk_25mhz  (clk_25mhz),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .color      (color),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int cnt;
        cnt = 0;
        wr_valid = 1'b1;
        wr_data  = b;
        while (!wr_ready && cnt < 3000) begin
            @(posedge clk_25mhz); #1;
            cnt++;
        end
        if (!wr_ready) chk("send_wait", 32'(wr_ready), 32'd1);
        @(posedge clk_25mhz); #1;
        wr_valid = 1'b0;
    endtask

    task automatic pix(input int px, input int py, output logic [23:0] c);
        x = 10'(px);
        y = 10'(py);
        repeat (3) @(posedge clk_25mhz);
        #1;
        c = color;
        x = 10'd700;
        y = 10'd0;
    endtask

    task automatic read_byte(input int col, input int lrow, input int grow, output logic [7:0] b);
        logic [23:0] c;
        for (int i = 0; i < 8; i++) begin
            pix(col * 8 + i, lrow * 16 + grow, c);
            b[7 - i] = (c == FG);
        end
    endtask

    task automatic pulse_origin();
        x = 10'd0;
        y = 10'd0;
        @(posedge clk_25mhz); #1;
        x = 10'd700;
        y = 10'd0;
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] c;
        logic [7:0]  b;
        logic [7:0]  m_row3;
        int          cnt;

        m_row3   = 8'he7;
        reset    = 1'b1;
        x        = 10'd700;
        y        = 10'd0;
        wr_valid = 1'b1;
        wr_data  = 8'h41;
        repeat (3) @(posedge clk_25mhz);
        #1;
        chk("rst_ready", 32'(wr_ready), 32'd0);
        chk("rst_color", 32'(color), 32'(BG));
        chk("rst_col", 32'(cursor_col), 32'd0);
        chk("rst_row", 32'(cursor_row), 32'd0);
        reset = 1'b0;

        cnt = 0;
        while (!wr_ready && cnt < 3000) begin
            @(posedge clk_25mhz); #1;
            cnt++;
            if (cnt == 1200) chk("clear_color", 32'(color), 32'(BG));
        end
        chk("clear_cycles", 32'(cnt), 32'd2400);
        @(posedge clk_25mhz); #1;
        wr_valid = 1'b0;
        chk("a_col", 32'(cursor_col), 32'd1);
        chk("a_row", 32'(cursor_row), 32'd0);

        // 'M' at (0,0), cursor parked on (1,0); stream x=0..7 to check exact latency
        send(8'h0d);
        send(8'h4d);
        y = 10'd3;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) x = 10'(i);
            if (i >= 3) chk($sformatf("m_px%0d", i - 3), 32'(color), m_row3[10 - i] ? 32'(FG) : 32'(BG));
            @(posedge clk_25mhz); #1;
        end
        x = 10'd700;
        y = 10'd0;

        pix(640, 3, c);
        chk("oob_x640", 32'(c), 32'(BG));
        pix(0, 483, c);
        chk("oob_y480", 32'(c), 32'(BG));

        pix(12, 5, c);
        chk("blink_f0", 32'(c), 32'(FG));
        pulse_origin();
        pix(12, 5, c);
        chk("blink_f1", 32'(c), 32'(BG));
        pulse_origin();
        pix(12, 5, c);
        chk("blink_f2", 32'(c), 32'(FG));
        pulse_origin();

        send(8'h0d);
        for (int i = 0; i < 80; i++) send(8'h78);
        chk("wrap_col", 32'(cursor_col), 32'd0);
        chk("wrap_row", 32'(cursor_row), 32'd1);
        read_byte(79, 0, 2, b);
        chk("wrap_c79", 32'(b), 32'h78);
        send(8'h79);
        chk("b81_col", 32'(cursor_col), 32'd1);
        chk("b81_row", 32'(cursor_row), 32'd1);
        read_byte(0, 1, 2, b);
        chk("b81_cell", 32'(b), 32'h79);

        send(8'h0c);
        for (int r = 0; r < 30; r++) begin
            send(8'(8'h21 + r));
            if (r < 29) send(8'h0a);
        end
        chk("fill_col", 32'(cursor_col), 32'd1);
        chk("fill_row", 32'(cursor_row), 32'd29);
        send(8'h0a);
        cnt = 0;
        while (!wr_ready && cnt < 200) begin
            @(posedge clk_25mhz); #1;
            cnt++;
        end
        chk("scroll_busy", 32'(cnt), 32'd80);
        chk("scroll_col", 32'(cursor_col), 32'd0);
        chk("scroll_row", 32'(cursor_row), 32'd29);
        read_byte(0, 0, 2, b);
        chk("scroll_top", 32'(b), 32'h22);
        read_byte(0, 28, 2, b);
        chk("scroll_r28", 32'(b), 32'h3e);
        read_byte(0, 29, 2, b);
        chk("scroll_blank", 32'(b), 32'h00);

        send(8'h08);
        chk("bs_col0", 32'(cursor_col), 32'd0);
        send(8'h41);
        send(8'h42);
        send(8'h0d);
        send(8'h43);
        chk("cr_col", 32'(cursor_col), 32'd1);
        read_byte(0, 29, 2, b);
        chk("cr_cell0", 32'(b), 32'h43);
        read_byte(1, 29, 2, b);
        chk("cr_cell1", 32'(b), 32'h42);
        send(8'h07);
        chk("bel_ready", 32'(wr_ready), 32'd1);
        chk("bel_col", 32'(cursor_col), 32'd1);
        chk("bel_row", 32'(cursor_row), 32'd29);
        send(8'h08);
        chk("bs_col1", 32'(cursor_col), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
